lu_row_mem_arbiter: RTL and testbench
=====================================

// Module: lu_row_mem_arbiter
// PURPOSE
//  Shares one single-port matrix row RAM (1 access/cycle, 1-cycle read latency) between three requesters:
//   - the LU engine write-back port;
//   - the LU engine row-read port;
//   - the host load/unload port.
//  Fixed priority, with a starvation guard for the host. Routes each read response back to its issuer.
//  Sits between the lu core and the row RAM.
// PARAMETERS
//  SIZE            4   matrix dimension; rows are addressed 0..SIZE-1
//  WIDTH           64  bits per real/imag part; a row is SIZE*2*WIDTH bits ({b,a} per element)
//  HOST_MAX_WAIT   8   host wait cycles before a forced grant; 0 disables forcing
//  AW = $clog2(SIZE), RW = SIZE*2*WIDTH (localparams)
// PORTS
//  clk_i          in   1    clock
//  rst_i          in   1    synchronous active-high reset
//  flush_i        in   1    drop in-flight read response, clear wait counter
//  lu_wr_valid_i  in   1    LU write-back request
//  lu_wr_addr_i   in   AW   LU write row address
//  lu_wr_data_i   in   RW   LU write row data
//  lu_wr_ready_o  out  1    LU write granted this cycle
//  lu_rd_valid_i  in   1    LU read request
//  lu_rd_addr_i   in   AW   LU read row address
//  lu_rd_ready_o  out  1    LU read granted this cycle
//  lu_rd_valid_o  out  1    LU read data valid (1 cycle after grant)
//  lu_rd_addr_o   out  AW   address of the returned LU row
//  lu_rd_data_o   out  RW   returned LU row
//  host_req_i     in   1    host access request
//  host_we_i      in   1    1 = write, 0 = read
//  host_addr_i    in   AW   host row address
//  host_wdata_i   in   RW   host write data
//  host_gnt_o     out  1    host granted this cycle
//  host_rvalid_o  out  1    host read data valid (1 cycle after grant)
//  host_rdata_o   out  RW   host read data
//  mem_en_o       out  1    RAM access enable
//  mem_we_o       out  1    RAM write enable
//  mem_addr_o     out  AW   RAM address
//  mem_wdata_o    out  RW   RAM write data
//  mem_rdata_i    in   RW   RAM read data, valid 1 cycle after a read enable
// BEHAVIOUR
//  - Grants are combinational from the current requests; at most one grant per cycle.
//    A request holds its address/data stable until granted.
//  - Priority: LU write > LU read > host.
//  - Forced host grant when HOST_MAX_WAIT != 0 and wait_cnt == HOST_MAX_WAIT:
//    the host wins that cycle over both LU ports.
//  - wait_cnt: +1 on each cycle with host_req_i && !host_gnt_o, saturating at HOST_MAX_WAIT.
//    Cleared on host grant, on !host_req_i, on flush_i, and on reset.
//  - mem_* outputs mirror the granted request; mem_en_o = 0 when nothing is granted.
//  - Read response: a registered tag {owner, addr, pending} is captured on each read grant.
//    Next cycle, mem_rdata_i is steered to lu_rd_data_o or host_rdata_o and exactly one rvalid pulses.
//    Each data output is driven whether or not its rvalid is high.
//  - Ordering: a write granted in cycle N is visible to a read granted in cycle N+1 or later; no bypass.
//  - Back-to-back reads from any mix of owners sustain 1 access/cycle.
//  - flush_i, same cycle as a grant: the grant still goes to RAM, but its response is suppressed
//    (no rvalid). Flush also suppresses a response already pending from the previous cycle.
//  - Reset (synchronous, any time, also mid-operation):
//    lu_rd_valid_o = 0, host_rvalid_o = 0, pending tag = 0, wait_cnt = 0.
//    Grant outputs and mem_en_o read 0 while rst_i is high.
//  - Out-of-range addresses (>= SIZE when SIZE is not a power of 2) are passed through unchecked.
// STRUCTURE
//  - Shared package lu_pkg: typedef row_t (logic [SIZE-1:0][2*WIDTH-1:0]); enum owner_e {OWN_LU, OWN_HOST}.
//  - One sub-module, lu_wait_guard: the saturating wait counter and force_host flag.
//  - Everything else is flat.
// TESTING
//  1 Reset: rst_i high for 3 cycles with all requests asserted -> all grants/rvalids 0, mem_en_o 0.
//  2 Host write row 2 = pattern P, then host read row 2 -> host_gnt_o each cycle;
//    host_rvalid_o one cycle after the read grant, host_rdata_o == P.
//  3 lu_wr_valid_i and lu_rd_valid_i (addr 1) in the same cycle -> write granted first,
//    read granted next cycle, returns the new data.
//  4 host_req_i held while the LU reads continuously, HOST_MAX_WAIT = 8 -> host granted
//    on the 9th request cycle, LU read stalled that cycle.
//  5 LU read granted with flush_i in the next cycle -> lu_rd_valid_o stays 0, wait_cnt 0.
//  6 Alternating LU/host reads every cycle -> one rvalid per cycle on the correct port,
//    with correct addr/data.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared types for the LU row-memory slice: row layout, read-response owner
// and sizing helpers used by the arbiter and its wait guard.
package lu_pkg;

    localparam int LU_SIZE  = 4;
    localparam int LU_WIDTH = 64;

    // One matrix row: SIZE elements, each {b, a} = {imag, real}.
    typedef logic [LU_SIZE-1:0][2*LU_WIDTH-1:0] row_t;

    // Who issued the read whose data returns next cycle.
    typedef enum logic {
        OWN_LU   = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    // Counter width able to hold 0..max_wait (at least one bit).
    function automatic int cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

    // Row address width (at least one bit).
    function automatic int addr_width(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/lu_wait_guard.sv
// Host starvation guard: counts consecutive cycles in which the host is
// requesting but not granted, saturating at HOST_MAX_WAIT. When saturated
// (and forcing is enabled) force_host_o tells the arbiter to hand the next
// cycle to the host regardless of LU traffic.
module lu_wait_guard
    import lu_pkg::*;
#(
    parameter int HOST_MAX_WAIT = 8,
    parameter int CW            = cnt_width(HOST_MAX_WAIT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          host_req_i,
    input  logic          host_gnt_i,
    output logic [CW-1:0] wait_cnt_o,
    output logic          force_host_o
);

    localparam logic [CW-1:0] MAX_CNT = CW'(HOST_MAX_WAIT);

    logic [CW-1:0] wait_cnt;

    // Count unserved host request cycles; any break in waiting restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || !host_req_i || host_gnt_i) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign wait_cnt_o   = wait_cnt;
    assign force_host_o = (HOST_MAX_WAIT != 0) && (wait_cnt == MAX_CNT);

endmodule

// File: rtl/lu_row_mem_arbiter.sv
// Arbitrates one single-port row RAM between the LU write-back port, the LU
// row-read port and the host port. Fixed priority LU write > LU read > host,
// overridden in favour of the host once it has waited HOST_MAX_WAIT cycles.
// A registered tag remembers who issued each read so the returning RAM data
// (one cycle later) raises exactly one rvalid on the right port.
//
// Handshake: a requester raises valid/req with address/data and holds them
// unchanged until its ready/gnt is seen high in the same cycle; the access
// reaches the RAM in that cycle. Read data returns the following cycle with a
// one-cycle rvalid pulse, unless flush_i is high in either cycle.
module lu_row_mem_arbiter
    import lu_pkg::*;
#(
    parameter int SIZE          = LU_SIZE,
    parameter int WIDTH         = LU_WIDTH,
    parameter int HOST_MAX_WAIT = 8,
    parameter int AW            = addr_width(SIZE),
    parameter int RW            = SIZE * 2 * WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,

    input  logic          lu_wr_valid_i,
    input  logic [AW-1:0] lu_wr_addr_i,
    input  logic [RW-1:0] lu_wr_data_i,
    output logic          lu_wr_ready_o,

    input  logic          lu_rd_valid_i,
    input  logic [AW-1:0] lu_rd_addr_i,
    output logic          lu_rd_ready_o,
    output logic          lu_rd_valid_o,
    output logic [AW-1:0] lu_rd_addr_o,
    output logic [RW-1:0] lu_rd_data_o,

    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [RW-1:0] host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [RW-1:0] host_rdata_o,

    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [RW-1:0] mem_wdata_o,
    input  logic [RW-1:0] mem_rdata_i
);

    localparam int CW = cnt_width(HOST_MAX_WAIT);

    logic          force_host;
    logic          host_forced;
    logic [CW-1:0] wait_cnt;

    logic          rd_gnt;
    owner_e        rd_owner;

    // Read-response tag captured on each read grant.
    logic          tag_pend;
    owner_e        tag_owner;
    logic [AW-1:0] tag_addr;

    lu_wait_guard #(
        .HOST_MAX_WAIT (HOST_MAX_WAIT),
        .CW            (CW)
    ) u_wait_guard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .host_req_i   (host_req_i),
        .host_gnt_i   (host_gnt_o),
        .wait_cnt_o   (wait_cnt),
        .force_host_o (force_host)
    );

    // The override only matters while the host is still asking.
    assign host_forced = force_host && host_req_i;

    // Single-winner grant decision; nothing is granted while in reset.
    always_comb begin
        lu_wr_ready_o = 1'b0;
        lu_rd_ready_o = 1'b0;
        host_gnt_o    = 1'b0;
        if (!rst_i) begin
            if (host_forced) begin
                host_gnt_o = 1'b1;
            end else if (lu_wr_valid_i) begin
                lu_wr_ready_o = 1'b1;
            end else if (lu_rd_valid_i) begin
                lu_rd_ready_o = 1'b1;
            end else if (host_req_i) begin
                host_gnt_o = 1'b1;
            end
        end
    end

    // Route the winning request onto the RAM port.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (lu_wr_ready_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = lu_wr_addr_i;
            mem_wdata_o = lu_wr_data_i;
        end else if (lu_rd_ready_o) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = lu_rd_addr_i;
        end else if (host_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = host_we_i;
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_wdata_i;
        end
    end

    // Classify the granted access as a read and name its owner.
    always_comb begin
        rd_gnt   = lu_rd_ready_o || (host_gnt_o && !host_we_i);
        rd_owner = host_gnt_o ? OWN_HOST : OWN_LU;
    end

    // Capture the read tag; a flush in the grant cycle cancels the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_pend  <= 1'b0;
            tag_owner <= OWN_LU;
            tag_addr  <= '0;
        end else begin
            tag_pend <= rd_gnt && !flush_i;
            if (rd_gnt) begin
                tag_owner <= rd_owner;
                tag_addr  <= mem_addr_o;
            end
        end
    end

    // Steer returning RAM data; a flush in the return cycle also drops it.
    always_comb begin
        lu_rd_valid_o = !rst_i && !flush_i && tag_pend && (tag_owner == OWN_LU);
        host_rvalid_o = !rst_i && !flush_i && tag_pend && (tag_owner == OWN_HOST);
        lu_rd_addr_o  = tag_addr;
        lu_rd_data_o  = mem_rdata_i;
        host_rdata_o  = mem_rdata_i;
    end

endmodule

// File: tb/tb_lu_row_mem_arbiter.sv
module tb_lu_row_mem_arbiter;

  localparam int SIZE  = 4;
  localparam int WIDTH = 64;
  localparam int MAXW  = 8;
  localparam int AW    = 2;
  localparam int RW    = SIZE * 2 * WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i;
  logic          lu_wr_valid_i, lu_wr_ready_o;
  logic [AW-1:0] lu_wr_addr_i;
  logic [RW-1:0] lu_wr_data_i;
  logic          lu_rd_valid_i, lu_rd_ready_o, lu_rd_valid_o;
  logic [AW-1:0] lu_rd_addr_i, lu_rd_addr_o;
  logic [RW-1:0] lu_rd_data_o;
  logic          host_req_i, host_we_i, host_gnt_o, host_rvalid_o;
  logic [AW-1:0] host_addr_i;
  logic [RW-1:0] host_wdata_i, host_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [RW-1:0] mem_wdata_o;
  logic [RW-1:0] mem_rdata_i;

  int checks = 0;
  int failures = 0;

  lu_row_mem_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH), .HOST_MAX_WAIT(MAXW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .lu_wr_valid_i(lu_wr_valid_i), .lu_wr_addr_i(lu_wr_addr_i),
    .lu_wr_data_i(lu_wr_data_i), .lu_wr_ready_o(lu_wr_ready_o),
    .lu_rd_valid_i(lu_rd_valid_i), .lu_rd_addr_i(lu_rd_addr_i),
    .lu_rd_ready_o(lu_rd_ready_o), .lu_rd_valid_o(lu_rd_valid_o),
    .lu_rd_addr_o(lu_rd_addr_o), .lu_rd_data_o(lu_rd_data_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // clock
  always #5 clk_i = ~clk_i;

  // single-port RAM environment, 1-cycle read latency
  logic [RW-1:0] ram [SIZE];
  initial begin
    for (int i = 0; i < SIZE; i++) ram[i] = '0;
    mem_rdata_i = '0;
  end
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else mem_rdata_i <= ram[mem_addr_o];
    end
  end

  // ---------------- reference model (transaction level) ----------------
  logic [RW-1:0] ref_mem [SIZE];
  int            ref_wait;
  bit            ref_pend, ref_pend_host;
  logic [AW-1:0] ref_addr;
  logic [RW-1:0] ref_data;

  bit            e_wr, e_rd, e_host, e_en, e_we, e_lu_rv, e_host_rv;
  logic [AW-1:0] e_addr;
  logic [RW-1:0] e_wdata;

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // who should win this cycle, and what response is due
  task automatic model_predict();
    e_wr = 0; e_rd = 0; e_host = 0;
    if (!rst_i) begin
      if (host_req_i && MAXW != 0 && ref_wait >= MAXW) e_host = 1;
      else if (lu_wr_valid_i) e_wr = 1;
      else if (lu_rd_valid_i) e_rd = 1;
      else if (host_req_i) e_host = 1;
    end
    e_en = e_wr || e_rd || e_host;
    e_we = e_wr || (e_host && host_we_i);
    e_addr = e_wr ? lu_wr_addr_i : e_rd ? lu_rd_addr_i : e_host ? host_addr_i : '0;
    e_wdata = e_wr ? lu_wr_data_i : host_wdata_i;
    e_lu_rv = !rst_i && !flush_i && ref_pend && !ref_pend_host;
    e_host_rv = !rst_i && !flush_i && ref_pend && ref_pend_host;
  endtask

  task automatic model_commit();
    if (rst_i) begin
      ref_wait = 0; ref_pend = 0;
      return;
    end
    if (e_wr) ref_mem[lu_wr_addr_i] = lu_wr_data_i;
    if (e_host && host_we_i) ref_mem[host_addr_i] = host_wdata_i;
    if (e_rd || (e_host && !host_we_i)) begin
      ref_pend = !flush_i;
      ref_pend_host = e_host;
      ref_addr = e_addr;
      ref_data = ref_mem[e_addr];
    end else begin
      ref_pend = 0;
    end
    if (flush_i || !host_req_i || e_host) ref_wait = 0;
    else if (ref_wait < MAXW) ref_wait++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flush_i = 0;
    lu_wr_valid_i = 0; lu_wr_addr_i = '0; lu_wr_data_i = '0;
    lu_rd_valid_i = 0; lu_rd_addr_i = '0;
    host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_wdata_i = '0;
  endtask

  task automatic settle();
    #1;
    model_predict();
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1; flush_i = 0;
    lu_wr_valid_i = 1; lu_wr_addr_i = 1; lu_wr_data_i = rand_row();
    lu_rd_valid_i = 1; lu_rd_addr_i = 2;
    host_req_i = 1; host_we_i = 0; host_addr_i = 3; host_wdata_i = '0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (lu_wr_ready_o !== 1'b0) begin failures++; $display("FAIL reset_lu_wr_ready got=%b exp=0", lu_wr_ready_o); end
      checks++; if (lu_rd_ready_o !== 1'b0) begin failures++; $display("FAIL reset_lu_rd_ready got=%b exp=0", lu_rd_ready_o); end
      checks++; if (host_gnt_o !== 1'b0) begin failures++; $display("FAIL reset_host_gnt got=%b exp=0", host_gnt_o); end
      checks++; if (mem_en_o !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en_o); end
      checks++; if (lu_rd_valid_o !== 1'b0 || host_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", lu_rd_valid_o, host_rvalid_o); end
      tick();
    end
    rst_i = 0;
    idle_inputs();
    settle();
    checks++; if (dut.wait_cnt !== '0) begin failures++; $display("FAIL reset_wait_cnt got=%0d exp=0", dut.wait_cnt); end
    checks++; if (lu_rd_valid_o !== 1'b0 || host_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_tag_clear got=%b%b exp=00", lu_rd_valid_o, host_rvalid_o); end
    tick();
  endtask

  task automatic test_host_rw();
    logic [RW-1:0] p;
    p = rand_row();
    host_req_i = 1; host_we_i = 1; host_addr_i = 2; host_wdata_i = p;
    settle();
    checks++; if (host_gnt_o !== 1'b1) begin failures++; $display("FAIL host_wr_gnt got=%b exp=1", host_gnt_o); end
    checks++; if ({mem_en_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b1, 2'd2}) begin failures++; $display("FAIL host_wr_mem got=%b%b%0d exp=112", mem_en_o, mem_we_o, mem_addr_o); end
    checks++; if (mem_wdata_o !== p) begin failures++; $display("FAIL host_wr_data got=%h exp=%h", mem_wdata_o, p); end
    tick();
    host_we_i = 0; host_wdata_i = '0;
    settle();
    checks++; if (host_gnt_o !== 1'b1 || mem_we_o !== 1'b0) begin failures++; $display("FAIL host_rd_gnt got=%b/%b exp=1/0", host_gnt_o, mem_we_o); end
    tick();
    idle_inputs();
    settle();
    checks++; if (host_rvalid_o !== 1'b1 || lu_rd_valid_o !== 1'b0) begin failures++; $display("FAIL host_rvalid got=%b lu=%b exp=1 lu=0", host_rvalid_o, lu_rd_valid_o); end
    checks++; if (host_rdata_o !== p) begin failures++; $display("FAIL host_rdata got=%h exp=%h", host_rdata_o, p); end
    tick();
  endtask

  task automatic test_wr_then_rd();
    logic [RW-1:0] d;
    d = rand_row();
    lu_wr_valid_i = 1; lu_wr_addr_i = 1; lu_wr_data_i = d;
    lu_rd_valid_i = 1; lu_rd_addr_i = 1;
    settle();
    checks++; if ({lu_wr_ready_o, lu_rd_ready_o} !== 2'b10) begin failures++; $display("FAIL wr_first got=%b%b exp=10", lu_wr_ready_o, lu_rd_ready_o); end
    tick();
    lu_wr_valid_i = 0;
    settle();
    checks++; if ({lu_wr_ready_o, lu_rd_ready_o} !== 2'b01) begin failures++; $display("FAIL rd_second got=%b%b exp=01", lu_wr_ready_o, lu_rd_ready_o); end
    tick();
    idle_inputs();
    settle();
    checks++; if (lu_rd_valid_o !== 1'b1 || lu_rd_addr_o !== 2'd1) begin failures++; $display("FAIL wr_rd_resp got=%b@%0d exp=1@1", lu_rd_valid_o, lu_rd_addr_o); end
    checks++; if (lu_rd_data_o !== d) begin failures++; $display("FAIL wr_rd_data got=%h exp=%h", lu_rd_data_o, d); end
    tick();
  endtask

  task automatic test_starvation();
    host_req_i = 1; host_we_i = 0; host_addr_i = 3;
    for (int k = 1; k <= MAXW + 1; k++) begin
      lu_rd_valid_i = 1; lu_rd_addr_i = AW'($urandom_range(0, SIZE - 1));
      settle();
      if (k <= MAXW) begin
        checks++; if ({lu_rd_ready_o, host_gnt_o} !== 2'b10) begin failures++; $display("FAIL starve_lu_k%0d got=%b%b exp=10", k, lu_rd_ready_o, host_gnt_o); end
      end else begin
        checks++; if ({lu_rd_ready_o, host_gnt_o} !== 2'b01) begin failures++; $display("FAIL starve_force_k%0d got=%b%b exp=01", k, lu_rd_ready_o, host_gnt_o); end
      end
      checks++; if (lu_rd_valid_o !== e_lu_rv || (e_lu_rv && lu_rd_data_o !== ref_data)) begin failures++; $display("FAIL starve_resp_k%0d got=%b exp=%b", k, lu_rd_valid_o, e_lu_rv); end
      tick();
    end
    idle_inputs();
    settle();
    checks++; if (host_rvalid_o !== 1'b1 || host_rdata_o !== ref_mem[3]) begin failures++; $display("FAIL starve_host_resp got=%b %h exp=1 %h", host_rvalid_o, host_rdata_o, ref_mem[3]); end
    tick();
  endtask

  task automatic test_flush();
    lu_rd_valid_i = 1; lu_rd_addr_i = 0;
    host_req_i = 1; host_we_i = 0; host_addr_i = 2;
    settle();
    checks++; if (lu_rd_ready_o !== 1'b1) begin failures++; $display("FAIL flush_grant got=%b exp=1", lu_rd_ready_o); end
    tick();
    lu_rd_addr_i = 1; flush_i = 1;
    settle();
    checks++; if (lu_rd_valid_o !== 1'b0) begin failures++; $display("FAIL flush_pending got=%b exp=0", lu_rd_valid_o); end
    checks++; if ({mem_en_o, lu_rd_ready_o, host_gnt_o} !== 3'b110) begin failures++; $display("FAIL flush_same_gnt got=%b%b%b exp=110", mem_en_o, lu_rd_ready_o, host_gnt_o); end
    tick();
    idle_inputs();
    settle();
    checks++; if (lu_rd_valid_o !== 1'b0 || host_rvalid_o !== 1'b0) begin failures++; $display("FAIL flush_suppressed got=%b%b exp=00", lu_rd_valid_o, host_rvalid_o); end
    checks++; if (dut.wait_cnt !== '0) begin failures++; $display("FAIL flush_wait_cnt got=%0d exp=0", dut.wait_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] prev_addr;
    logic [RW-1:0] prev_data;
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      if (i < 11) begin
        if (i % 2 == 0) begin lu_rd_valid_i = 1; lu_rd_addr_i = AW'($urandom_range(0, SIZE - 1)); end
        else begin host_req_i = 1; host_addr_i = AW'($urandom_range(0, SIZE - 1)); end
      end
      settle();
      if (i > 0) begin
        checks++; if ({lu_rd_valid_o, host_rvalid_o} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL b2b_port_%0d got=%b%b", i, lu_rd_valid_o, host_rvalid_o); end
        checks++; if (lu_rd_data_o !== prev_data || host_rdata_o !== prev_data) begin failures++; $display("FAIL b2b_data_%0d got=%h exp=%h", i, lu_rd_data_o, prev_data); end
        if (i % 2 == 1) begin
          checks++; if (lu_rd_addr_o !== prev_addr) begin failures++; $display("FAIL b2b_addr_%0d got=%0d exp=%0d", i, lu_rd_addr_o, prev_addr); end
        end
      end
      if (i < 11) begin
        checks++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0) begin failures++; $display("FAIL b2b_issue_%0d got=%b%b exp=10", i, mem_en_o, mem_we_o); end
      end
      prev_addr = (i % 2 == 0) ? lu_rd_addr_i : host_addr_i;
      prev_data = ref_mem[prev_addr];
      tick();
    end
  endtask

  task automatic test_random();
    bit g_wr, g_rd, g_host;
    for (int n = 0; n < 400; n++) begin
      if (!lu_wr_valid_i && $urandom_range(0, 3) == 0) begin
        lu_wr_valid_i = 1; lu_wr_addr_i = AW'($urandom_range(0, SIZE - 1)); lu_wr_data_i = rand_row();
      end
      if (!lu_rd_valid_i && $urandom_range(0, 2) == 0) begin
        lu_rd_valid_i = 1; lu_rd_addr_i = AW'($urandom_range(0, SIZE - 1));
      end
      if (!host_req_i && $urandom_range(0, 2) == 0) begin
        host_req_i = 1; host_we_i = 1'($urandom_range(0, 1));
        host_addr_i = AW'($urandom_range(0, SIZE - 1)); host_wdata_i = rand_row();
      end
      flush_i = ($urandom_range(0, 15) == 0);
      settle();
      checks++; if ({lu_wr_ready_o, lu_rd_ready_o, host_gnt_o} !== {e_wr, e_rd, e_host}) begin failures++; $display("FAIL rnd_grant_%0d got=%b%b%b exp=%b%b%b", n, lu_wr_ready_o, lu_rd_ready_o, host_gnt_o, e_wr, e_rd, e_host); end
      checks++; if (mem_en_o !== e_en || (e_en && (mem_we_o !== e_we || mem_addr_o !== e_addr))) begin failures++; $display("FAIL rnd_mem_%0d got=%b%b@%0d exp=%b%b@%0d", n, mem_en_o, mem_we_o, mem_addr_o, e_en, e_we, e_addr); end
      if (e_en && e_we) begin
        checks++; if (mem_wdata_o !== e_wdata) begin failures++; $display("FAIL rnd_wdata_%0d got=%h exp=%h", n, mem_wdata_o, e_wdata); end
      end
      checks++; if ({lu_rd_valid_o, host_rvalid_o} !== {e_lu_rv, e_host_rv}) begin failures++; $display("FAIL rnd_rvalid_%0d got=%b%b exp=%b%b", n, lu_rd_valid_o, host_rvalid_o, e_lu_rv, e_host_rv); end
      if (e_lu_rv) begin
        checks++; if (lu_rd_addr_o !== ref_addr || lu_rd_data_o !== ref_data) begin failures++; $display("FAIL rnd_lu_data_%0d got=%0d:%h exp=%0d:%h", n, lu_rd_addr_o, lu_rd_data_o, ref_addr, ref_data); end
      end
      if (e_host_rv) begin
        checks++; if (host_rdata_o !== ref_data) begin failures++; $display("FAIL rnd_host_data_%0d got=%h exp=%h", n, host_rdata_o, ref_data); end
      end
      g_wr = e_wr; g_rd = e_rd; g_host = e_host;
      tick();
      if (g_wr) lu_wr_valid_i = 0;
      if (g_rd) lu_rd_valid_i = 0;
      if (g_host) host_req_i = 0;
    end
    idle_inputs();
    settle();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < SIZE; i++) ref_mem[i] = '0;
    ref_wait = 0; ref_pend = 0; ref_pend_host = 0; ref_addr = '0; ref_data = '0;
    idle_inputs();
    rst_i = 1;
    test_reset();
    test_host_rw();
    test_wr_then_rd();
    test_starvation();
    test_flush();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
